mdc_stream_engine_ctrl: RTL and testbench

- Parametrised, multi-channel successor to the single-in/single-out MDC engine wrapper.
- Sits between the HWPE streamer and an MDC dataflow core. Buffers N_IN input streams and N_OUT output streams in per-channel FIFOs.
- Counts tokens against a programmed job length, sequences the job with an FSM, and reports busy/done to the HWPE controller.

---
 rtl/mdc_stream_engine_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_mdc_stream_engine_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdc_stream_engine_ctrl.sv
// mdc_stream_engine_ctrl
//   Multi-channel controller between the HWPE streamer and an MDC dataflow
//   core. Each input stream and each output stream is buffered in its own
//   small FIFO. Tokens are counted against a programmed job length, and an FSM
//   (IDLE -> RUN -> DRAIN -> DONE) sequences the job and reports busy/done.
//
//   Handshake rule for every stream: a token moves on a rising clock edge where
//   valid and ready are both high. Ready never depends on valid. Valid never
//   depends on ready.
//
//   Optional feature: define MDC_STREAM_ENGINE_TIMEOUT_EN to build a watchdog.
//   It ends a RUN/DRAIN phase that has had no handshake on any channel for
//   TIMEOUT_CYCLES consecutive cycles. When it fires it raises the sticky err_o,
//   pulses done_o and flushes the FIFOs. Without the macro, err_o stays 0.
//
//   Ports
//     clk_i, rst_i, clear_i  clock, sync active-high reset, sync soft clear
//     start_i, len_i         job start pulse and tokens per channel
//     in_*                   streamer -> engine input streams (N_IN)
//     mdc_in_*               engine -> MDC core input streams (N_IN)
//     mdc_out_*              MDC core -> engine output streams (N_OUT)
//     out_*                  engine -> streamer output streams (N_OUT)
//     busy_o, done_o, err_o  job status
//     dbg_state_o            current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)

module mdc_stream_fifo #(
   parameter int DW    = 32,
   parameter int DEPTH = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [DW-1:0] data_i,
   output logic [DW-1:0] data_o,
   output logic          full_o,
   output logic          empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          do_push, do_pop;

   assign full_o  = (count == (AW+1)'(DEPTH));
   assign empty_o = (count == '0);
   // A full FIFO refuses a push even when it pops in the same cycle.
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   // The head is forced to zero when the FIFO is empty, so stale entries never show on the output.
   assign data_o  = empty_o ? '0 : mem[rd_ptr];

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= data_i;
   end

   // Pointers are AW bits wide, so they wrap modulo DEPTH (a power of two).
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end
endmodule

module mdc_stream_engine_ctrl #(
   parameter int N_IN           = 2,
   parameter int N_OUT          = 1,
   parameter int DATA_WIDTH     = 32,
   parameter int FIFO_DEPTH     = 4,
   parameter int CNT_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        clear_i,
   input  logic                        start_i,
   input  logic [CNT_WIDTH-1:0]        len_i,
   input  logic [N_IN-1:0]             in_valid_i,
   input  logic [N_IN*DATA_WIDTH-1:0]  in_data_i,
   output logic [N_IN-1:0]             in_ready_o,
   output logic [N_IN-1:0]             mdc_in_valid_o,
   output logic [N_IN*DATA_WIDTH-1:0]  mdc_in_data_o,
   input  logic [N_IN-1:0]             mdc_in_ready_i,
   input  logic [N_OUT-1:0]            mdc_out_valid_i,
   input  logic [N_OUT*DATA_WIDTH-1:0] mdc_out_data_i,
   output logic [N_OUT-1:0]            mdc_out_ready_o,
   output logic [N_OUT-1:0]            out_valid_o,
   output logic [N_OUT*DATA_WIDTH-1:0] out_data_o,
   input  logic [N_OUT-1:0]            out_ready_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        err_o,
   output logic [1:0]                  dbg_state_o
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

   if (FIFO_DEPTH < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("mdc_stream_engine_ctrl: FIFO_DEPTH must be >= 2 and TIMEOUT_CYCLES >= 1");
   end

   state_t               state;
   logic                 busy_q, done_q, err_q, abort_q;
   logic [CNT_WIDTH-1:0] len_q;
   logic [CNT_WIDTH-1:0] ic [N_IN];
   logic [CNT_WIDTH-1:0] oc [N_OUT];
   logic [N_IN-1:0]      in_full, in_empty, in_push, in_pop, ic_done;
   logic [N_OUT-1:0]     out_full, out_empty, out_push, out_pop, oc_done;
   logic                 run, active, all_empty, fifo_flush, timeout;

   assign run        = (state == S_RUN);
   assign active     = (state == S_RUN) || (state == S_DRAIN);
   assign all_empty  = (&in_empty) & (&out_empty);
   // abort_q is set only while in DONE after a watchdog expiry, so the flush happens on that DONE cycle.
   assign fifo_flush = clear_i | abort_q;

   always_comb begin
      ic_done = '0;
      oc_done = '0;
      for (int k = 0; k < N_IN; k++)  ic_done[k] = (ic[k] == len_q);
      for (int j = 0; j < N_OUT; j++) oc_done[j] = (oc[j] == len_q);
   end

   // Input side stops accepting at len, which also saturates ic.
   assign in_ready_o      = {N_IN{run}} & ~in_full & ~ic_done;
   assign in_push         = in_valid_i & in_ready_o;
   assign mdc_in_valid_o  = {N_IN{active}} & ~in_empty;
   assign in_pop          = mdc_in_valid_o & mdc_in_ready_i;
   assign mdc_out_ready_o = {N_OUT{active}} & ~out_full;
   assign out_push        = mdc_out_valid_i & mdc_out_ready_o;
   assign out_valid_o     = ~out_empty;
   assign out_pop         = out_valid_o & out_ready_i;

   for (genvar k = 0; k < N_IN; k++) begin : g_in_fifo
      mdc_stream_fifo #(.DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .flush_i (fifo_flush),
         .push_i  (in_push[k]),
         .pop_i   (in_pop[k]),
         .data_i  (in_data_i[k*DATA_WIDTH +: DATA_WIDTH]),
         .data_o  (mdc_in_data_o[k*DATA_WIDTH +: DATA_WIDTH]),
         .full_o  (in_full[k]),
         .empty_o (in_empty[k])
      );
   end

   for (genvar j = 0; j < N_OUT; j++) begin : g_out_fifo
      mdc_stream_fifo #(.DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .flush_i (fifo_flush),
         .push_i  (out_push[j]),
         .pop_i   (out_pop[j]),
         .data_i  (mdc_out_data_i[j*DATA_WIDTH +: DATA_WIDTH]),
         .data_o  (out_data_o[j*DATA_WIDTH +: DATA_WIDTH]),
         .full_o  (out_full[j]),
         .empty_o (out_empty[j])
      );
   end

   // Token counters. Surplus output tokens beyond len are still delivered but not counted.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i || (state == S_IDLE && start_i)) begin
         for (int k = 0; k < N_IN; k++)  ic[k] <= '0;
         for (int j = 0; j < N_OUT; j++) oc[j] <= '0;
      end else begin
         for (int k = 0; k < N_IN; k++)
            if (in_push[k]) ic[k] <= ic[k] + 1'b1;
         for (int j = 0; j < N_OUT; j++)
            if (out_pop[j] && !oc_done[j]) oc[j] <= oc[j] + 1'b1;
      end
   end

`ifdef MDC_STREAM_ENGINE_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt;
   logic            any_xfer;

   assign any_xfer = |{in_push, in_pop, out_push, out_pop};
   // Fires at the edge that closes the TIMEOUT_CYCLES-th handshake-free cycle.
   assign timeout  = active & ~any_xfer & (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i || !active || any_xfer) wd_cnt <= '0;
      else if (!timeout)                           wd_cnt <= wd_cnt + 1'b1;
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         state   <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         abort_q <= 1'b0;
         len_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               abort_q <= 1'b0;
               if (start_i) begin
                  len_q <= len_i;
                  if (len_i == '0) begin
                     state  <= S_DONE;
                     done_q <= 1'b1;
                  end else begin
                     state  <= S_RUN;
                     busy_q <= 1'b1;
                  end
               end
            end
            S_RUN, S_DRAIN: begin
               if (timeout) begin
                  state   <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
                  abort_q <= 1'b1;
               end else if (state == S_RUN && (&ic_done)) begin
                  state <= S_DRAIN;
               end else if (state == S_DRAIN && (&oc_done) && all_empty) begin
                  state  <= S_DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            default: begin
               state   <= S_IDLE;
               abort_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign dbg_state_o = state;
endmodule

// File: tb/tb_mdc_stream_engine_ctrl.sv
// Testbench for mdc_stream_engine_ctrl with N_IN=2 and N_OUT=1.
// The MDC core model adds the two input tokens. Expected sums are queued in exp_q
// and compared when each token leaves on the output stream.
module tb_mdc_stream_engine_ctrl;
   localparam int N_IN  = 2;
   localparam int N_OUT = 1;
   localparam int DW    = 32;
   localparam int CW    = 16;

   logic                 clk = 1'b0;
   logic                 rst_i, clear_i, start_i;
   logic [CW-1:0]        len_i;
   logic [N_IN-1:0]      in_valid_i, in_ready_o, mdc_in_valid_o, mdc_in_ready_i;
   logic [N_IN*DW-1:0]   in_data_i, mdc_in_data_o;
   logic [N_OUT-1:0]     mdc_out_valid_i, mdc_out_ready_o, out_valid_o, out_ready_i;
   logic [N_OUT*DW-1:0]  mdc_out_data_i, out_data_o;
   logic                 busy_o, done_o, err_o;
   logic [1:0]           dbg_state_o;

   mdc_stream_engine_ctrl #(
      .N_IN(N_IN), .N_OUT(N_OUT), .DATA_WIDTH(DW), .FIFO_DEPTH(4),
      .CNT_WIDTH(CW), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i), .len_i(len_i),
      .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
      .mdc_in_valid_o(mdc_in_valid_o), .mdc_in_data_o(mdc_in_data_o),
      .mdc_in_ready_i(mdc_in_ready_i), .mdc_out_valid_i(mdc_out_valid_i),
      .mdc_out_data_i(mdc_out_data_i), .mdc_out_ready_o(mdc_out_ready_o),
      .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .dbg_state_o(dbg_state_o)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL sim_timeout: simulation exceeded time limit");
      $fatal(1, "time limit");
   end

   // ---------------- MDC core model: sum of both inputs ----------------
   logic mdc_en, mdc_fire;
   always_comb begin
      mdc_fire        = mdc_en && (&mdc_in_valid_o) && mdc_out_ready_o[0];
      mdc_in_ready_i  = {N_IN{mdc_fire}};
      mdc_out_valid_i = mdc_fire;
      mdc_out_data_i  = mdc_in_data_o[0 +: DW] + mdc_in_data_o[DW +: DW];
   end

   // ---------------- bench state ----------------
   typedef struct {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] sum;
   } vec_t;
   vec_t vecs [8];

   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] src [N_IN][64];
   int idx [N_IN];
   int xfer_cnt [N_IN];
   int src_cnt, done_cnt, errors, checks;
   bit feed, ir_seen, busy_seen;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_inputs();
      for (int k = 0; k < N_IN; k++) begin
         in_valid_i[k] = feed && (idx[k] < src_cnt);
         in_data_i[k*DW +: DW] = (idx[k] < 64) ? src[k][idx[k]] : '0;
      end
   endtask

   // Samples just before the next edge: scoreboard and counters. Then it steps one cycle and drives the new inputs.
   task automatic tick();
      logic [DW-1:0] e;
      #1;
      if (out_valid_o[0] && out_ready_i[0]) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_extra: got 0x%0h expected no token", out_data_o);
         end else begin
            e = exp_q.pop_front();
            chk("out_data", out_data_o, e);
         end
      end
      for (int k = 0; k < N_IN; k++)
         if (in_valid_i[k] && in_ready_o[k]) begin
            idx[k]++;
            xfer_cnt[k]++;
         end
      if (done_o) done_cnt++;
      if (|in_ready_o) ir_seen = 1'b1;
      if (busy_o) busy_seen = 1'b1;
      @(posedge clk);
      #1;
      drive_inputs();
   endtask

   task automatic setup_job(input int n, input int avail);
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         src[0][i] = DW'(i * 3 + 100);
         src[1][i] = DW'(i * 7 + 1);
         exp_q.push_back(src[0][i] + src[1][i]);
      end
      for (int i = n; i < 64; i++) begin
         src[0][i] = DW'(32'hdead_0000 + i);
         src[1][i] = DW'(32'hbeef_0000 + i);
      end
      for (int k = 0; k < N_IN; k++) begin
         idx[k] = 0;
         xfer_cnt[k] = 0;
      end
      src_cnt = avail;
      done_cnt = 0;
      ir_seen = 1'b0;
      busy_seen = 1'b0;
      feed = 1'b1;
      drive_inputs();
   endtask

   task automatic start_job(input int n);
      len_i = CW'(n);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      bit got, busy_ok;
      got = 1'b0;
      busy_ok = 1'b1;
      for (int i = 0; i < budget; i++) begin
         if (done_o) begin
            got = 1'b1;
            break;
         end
         if (!busy_o) busy_ok = 1'b0;
         tick();
      end
      chk({name, "_done_seen"}, got, 1);
      chk({name, "_busy_held"}, busy_ok, 1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      errors = 0;
      checks = 0;
      rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; len_i = '0;
      in_valid_i = '0; in_data_i = '0; out_ready_i = '1; mdc_en = 1'b1; feed = 1'b0;
      src_cnt = 0; done_cnt = 0;
      for (int k = 0; k < N_IN; k++) begin idx[k] = 0; xfer_cnt[k] = 0; end

      // Basic job vectors: {a, b, a+b} with hand-computed sums, including wrap-around.
      vecs[0] = '{32'd1,          32'd2,          32'd3};
      vecs[1] = '{32'd10,         32'd20,         32'd30};
      vecs[2] = '{32'hffff_ffff,  32'd1,          32'h0000_0000};
      vecs[3] = '{32'h8000_0000,  32'h8000_0000,  32'h0000_0000};
      vecs[4] = '{32'h1234_5678,  32'h1111_1111,  32'h2345_6789};
      vecs[5] = '{32'd0,          32'd0,          32'd0};
      vecs[6] = '{32'h0000_ffff,  32'h0000_0001,  32'h0001_0000};
      vecs[7] = '{32'd100,        32'd200,        32'd300};

      repeat (3) tick();
      rst_i = 1'b0;
      chk("rst_state", dbg_state_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_in_ready", in_ready_o, 0);
      chk("rst_mdc_in_valid", mdc_in_valid_o, 0);
      chk("rst_mdc_out_ready", mdc_out_ready_o, 0);
      chk("rst_out_valid", out_valid_o, 0);
      chk("rst_out_data", out_data_o, 0);

      // ---- basic job, len=8, table-driven ----
      setup_job(8, 8);
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin
         src[0][i] = vecs[i].a;
         src[1][i] = vecs[i].b;
         exp_q.push_back(vecs[i].sum);
      end
      drive_inputs();
      chk("basic_idle_in_ready", in_ready_o, 0);
      start_job(8);
      chk("basic_busy_after_start", busy_o, 1);
      chk("basic_state_run", dbg_state_o, 1);
      wait_done("basic", 100);
      chk("basic_state_done", dbg_state_o, 3);
      chk("basic_busy_in_done", busy_o, 0);
      repeat (3) tick();
      chk("basic_done_pulses", done_cnt, 1);
      chk("basic_exp_left", exp_q.size(), 0);
      chk("basic_xfer0", xfer_cnt[0], 8);
      chk("basic_xfer1", xfer_cnt[1], 8);
      chk("basic_state_idle", dbg_state_o, 0);

      // ---- backpressure, len=16 ----
      setup_job(16, 16);
      start_job(16);
      repeat (4) tick();
      out_ready_i = '0;
      repeat (20) tick();
      chk("bp_in_ready_low", in_ready_o, 0);
      chk("bp_mdc_out_ready_low", mdc_out_ready_o, 0);
      chk("bp_out_valid", out_valid_o, 1);
      chk("bp_still_busy", busy_o, 1);
      out_ready_i = '1;
      wait_done("bp", 200);
      repeat (3) tick();
      chk("bp_done_pulses", done_cnt, 1);
      chk("bp_exp_left", exp_q.size(), 0);
      chk("bp_xfer0", xfer_cnt[0], 16);
      chk("bp_xfer1", xfer_cnt[1], 16);

      // ---- zero length ----
      setup_job(0, 4);
      start_job(0);
      chk("zl_done", done_o, 1);
      chk("zl_state_done", dbg_state_o, 3);
      tick();
      chk("zl_done_cleared", done_o, 0);
      chk("zl_state_idle", dbg_state_o, 0);
      repeat (4) tick();
      chk("zl_in_ready_never", ir_seen, 0);
      chk("zl_busy_never", busy_seen, 0);
      chk("zl_done_pulses", done_cnt, 1);
      chk("zl_xfer0", xfer_cnt[0], 0);
      feed = 1'b0;
      drive_inputs();

      // ---- surplus input and ignored start, len=4 ----
      setup_job(4, 10);
      start_job(4);
      for (int i = 0; i < 10; i++) begin
         if (i == 1) begin
            start_i = 1'b1;
            len_i = CW'(7);
         end
         if (i == 2) start_i = 1'b0;
         if (i == 5) chk("sur_in_ready_low", in_ready_o, 0);
         tick();
      end
      feed = 1'b0;
      drive_inputs();
      repeat (10) tick();
      chk("sur_xfer0", xfer_cnt[0], 4);
      chk("sur_xfer1", xfer_cnt[1], 4);
      chk("sur_done_pulses", done_cnt, 1);
      chk("sur_exp_left", exp_q.size(), 0);
      chk("sur_state_idle", dbg_state_o, 0);

      // ---- clear mid-job, len=10, then a fresh len=3 job ----
      setup_job(10, 10);
      out_ready_i = '0;
      start_job(10);
      for (int i = 0; i < 50 && xfer_cnt[0] < 5; i++) tick();
      chk("clr_reached_5", xfer_cnt[0] >= 5, 1);
      chk("clr_out_valid_before", out_valid_o, 1);
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      feed = 1'b0;
      drive_inputs();
      chk("clr_state_idle", dbg_state_o, 0);
      chk("clr_busy", busy_o, 0);
      chk("clr_done", done_o, 0);
      chk("clr_out_valid", out_valid_o, 0);
      chk("clr_mdc_in_valid", mdc_in_valid_o, 0);
      chk("clr_in_ready", in_ready_o, 0);
      out_ready_i = '1;
      repeat (3) tick();
      chk("clr_no_done", done_cnt, 0);
      chk("clr_out_still_empty", out_valid_o, 0);
      setup_job(3, 3);
      start_job(3);
      wait_done("fresh", 100);
      repeat (3) tick();
      chk("fresh_done_pulses", done_cnt, 1);
      chk("fresh_exp_left", exp_q.size(), 0);

`ifdef MDC_STREAM_ENGINE_TIMEOUT_EN
      // ---- watchdog: core never ready ----
      begin
         bit early;
         mdc_en = 1'b0;
         setup_job(4, 4);
         start_job(4);
         for (int i = 0; i < 20 && xfer_cnt[0] < 4; i++) tick();
         chk("tmo_inputs_in", xfer_cnt[0], 4);
         early = 1'b0;
         for (int i = 0; i < 16; i++) begin
            if (done_o || err_o) early = 1'b1;
            tick();
         end
         chk("tmo_not_early", early, 0);
         chk("tmo_done", done_o, 1);
         chk("tmo_err", err_o, 1);
         chk("tmo_state_done", dbg_state_o, 3);
         tick();
         chk("tmo_state_idle", dbg_state_o, 0);
         repeat (5) tick();
         chk("tmo_err_sticky", err_o, 1);
         chk("tmo_done_pulses", done_cnt, 1);
         clear_i = 1'b1;
         tick();
         clear_i = 1'b0;
         chk("tmo_err_cleared", err_o, 0);
         mdc_en = 1'b1;
         feed = 1'b0;
         drive_inputs();
      end
`else
      chk("no_wd_err_low", err_o, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
